cddip_ib_arbiter: RTL and testbench
===================================

# cddip_ib_arbiter

Frame-granular round-robin arbiter that shares the single 64-bit AXI-stream inbound port of the CDD engine (`cr_cddip` ib_*) between NUM_CH independent command/data sources. A frame ends on tlast; the block holds its grant for the whole frame and never interleaves beats from different sources. It tags each output beat with the source index on tid. It sits directly in front of the engine ib port and registers its output through a 2-entry skid buffer, so the engine sees a clean, full-throughput stream.

## Interface
- NUM_CH, 4: number of requesting sources, 2..8.
- TID_W, `AXI_S_TID_WIDTH`: output tid width, ≥ clog2(NUM_CH).
- TIMEOUT_CYCLES, 10000: mid-frame stall limit, used only with the timeout feature.

- clk  in  1  engine clock.
- rst  in  1  reset, asynchronous, active-high.
- s_tvalid  in  NUM_CH  per-source valid.
- s_tready  out  NUM_CH  per-source ready.
- s_tdata  in  NUM_CH*64  per-source data; source i is [64i+63:64i].
- s_tstrb  in  NUM_CH*8  per-source byte strobes.
- s_tuser  in  NUM_CH*8  per-source tuser (01 SoT, 02 EoT, 03 mid, 00 none).
- s_tlast  in  NUM_CH  per-source end of frame.
- chan_en  in  NUM_CH  source enable mask for new grants.
- m_tvalid  out  1  to engine ib_tvalid.
- m_tready  in  1  from engine ib_tready.
- m_tdata  out  64  output data.
- m_tstrb  out  8  output strobes.
- m_tuser  out  8  output tuser.
- m_tlast  out  1  output tlast.
- m_tid  out  TID_W  index of the granted source, zero-extended.
- arb_idle  out  1  no grant held and skid buffer empty.
- timeout_err  out  NUM_CH  sticky stall flag per source; present only with CDDIP_IB_ARB_TIMEOUT_EN.

## Operation
- FSM states:
  - ARB: selects a winner from the requests `s_tvalid & chan_en`. The search starts at rr_ptr and runs upward with wrap. With no request, the FSM stays in ARB. Selecting a winner latches gnt, sets rr_ptr to gnt+1 (mod NUM_CH) and moves to PASS.
  - PASS: s_tready[gnt] = skid not full; all other s_tready bits are 0. An accepted beat (valid && ready) is written into the skid. An accepted beat with s_tlast set moves the FSM to ARB.
- One ARB cycle always separates frames. Every source gets a fair chance even with back-to-back traffic.
- Clearing chan_en[gnt] mid-frame has no effect on the current frame; the grant is held until tlast. A disabled source is skipped in ARB.
- A source that deasserts s_tvalid mid-frame stalls the arbiter in PASS. Other sources wait.
- Skid buffer: 2 entries of {data, strb, user, last, tid}. m_* is driven from the head entry; it pops on m_tvalid && m_tready.
- m_tid of each beat = gnt at the time the beat was accepted.
- arb_idle = (state==ARB) && skid empty.
- Values driven on unused s_tdata lanes are ignored.

## Timing
- Reset values: state ARB, rr_ptr 0, gnt 0, skid empty, m_tvalid 0, m_tlast 0, m_tdata/strb/user/tid 0, s_tready 0, arb_idle 1, timeout_err 0.
- rst asserted mid-frame discards the frame in flight, including skid contents. No partial frame completes after rst deassertion.
- Latency: a request seen in ARB at edge k gets s_tready high in cycle k+1. A beat accepted at edge j is on m_* (m_tvalid=1) in the cycle after edge j.
- Throughput: 1 beat/cycle while m_tready=1. A frame of L beats occupies L+1 input cycles (including ARB).
- m_tready low: the skid absorbs up to 2 beats. s_tready[gnt] falls in the cycle after the skid becomes full; there is no combinational path from m_tready to s_tready.
- m_* are stable while m_tvalid && !m_tready (AXI rule).
- Simultaneous pop and push on a full skid are legal only through the registered-ready scheme above; the skid never overflows.

## Configuration
- CDDIP_IB_ARB_TIMEOUT_EN defined:
  - A stall counter runs in PASS while s_tvalid[gnt]=0 and clears on each accepted beat.
  - When the counter reaches TIMEOUT_CYCLES, timeout_err[gnt] is set. It is sticky until rst.
  - Arbitration behaviour is unchanged; the block keeps waiting.
- Not defined: no counter is built, the timeout_err port is absent and TIMEOUT_CYCLES is unused.

## Structure
- Package cddip_ib_arb_pkg: the FSM state enum (ARB, PASS), the beat struct {data[63:0], strb[7:0], user[7:0], last, tid}, and the tuser codes SOT=8'h01, EOT=8'h02, MID=8'h03.
- Sub-module cddip_axis_skid: a 2-entry registered skid buffer parameterised on the beat struct. It is reusable for the ob path.
- The round-robin search is a function inside the top module.

## Test plan
- Single source, ch0, 4-beat frame (SoT 0x…09 / mid / mid / EoT+tlast), m_tready=1:
  - m_* matches the input 1 cycle later with m_tid=0.
  - arb_idle returns to 1 two cycles after the tlast beat.
- All 4 channels request continuously with 2-beat frames:
  - Grant order is 0,1,2,3,0.
  - No interleaving within a frame.
  - Each frame is separated by exactly 1 ARB cycle.
- m_tready held low for 5 cycles mid-frame:
  - At most 2 beats are buffered.
  - s_tready[gnt] is 0 until the skid drains.
  - No beat is lost or duplicated, and m_* is stable while stalled.
- chan_en[1] cleared during ch1's frame:
  - The frame completes through tlast.
  - Ch1 is not granted again while chan_en[1]=0, even with s_tvalid[1]=1.
- rst pulsed 1 cycle mid-frame on ch2:
  - All outputs return to their reset values.
  - After release, with ch2 and ch3 requesting, ch0 priority restarts (rr_ptr=0) and ch2 is granted first.
- With CDDIP_IB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, ch3 drops s_tvalid after beat 1:
  - timeout_err[3] rises at stall cycle 16 and stays set.
  - The frame completes normally when s_tvalid returns.

Source files
------------

// File: rtl/cddip_ib_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// cddip_ib_arb_pkg
// Shared types for the CDD engine inbound arbiter:
//   - arb_state_e : arbiter FSM states (ARB selects a source, PASS forwards it)
//   - ib_beat_t   : one AXI-stream beat as stored in the skid buffer
//   - SOT/EOT/MID : tuser codes carried on the stream
// Also provides a default for AXI_S_TID_WIDTH when the build does not set it.
// ---------------------------------------------------------------------------
`ifndef AXI_S_TID_WIDTH
`define AXI_S_TID_WIDTH 8
`endif

package cddip_ib_arb_pkg;

  localparam int TID_MAX_W = 8;  // widest tid a beat can carry

  typedef enum logic {
    ARB  = 1'b0,
    PASS = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [63:0]          data;
    logic [7:0]           strb;
    logic [7:0]           user;
    logic                 last;
    logic [TID_MAX_W-1:0] tid;
  } ib_beat_t;

  localparam logic [7:0] SOT = 8'h01;
  localparam logic [7:0] EOT = 8'h02;
  localparam logic [7:0] MID = 8'h03;

endpackage

// File: rtl/cddip_ib_arbiter_if.sv
// ---------------------------------------------------------------------------
// cddip_ib_arbiter_if
// Bundles the NUM_CH source streams (s_*) and the single engine-facing stream
// (m_*) of the inbound arbiter.
//   slave  : arbiter side (consumes s_*, produces m_*)
//   master : environment side (sources and engine)
// ---------------------------------------------------------------------------
interface cddip_ib_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int TID_W  = `AXI_S_TID_WIDTH
);
  logic [NUM_CH-1:0]    s_tvalid;
  logic [NUM_CH-1:0]    s_tready;
  logic [NUM_CH*64-1:0] s_tdata;
  logic [NUM_CH*8-1:0]  s_tstrb;
  logic [NUM_CH*8-1:0]  s_tuser;
  logic [NUM_CH-1:0]    s_tlast;

  logic                 m_tvalid;
  logic                 m_tready;
  logic [63:0]          m_tdata;
  logic [7:0]           m_tstrb;
  logic [7:0]           m_tuser;
  logic                 m_tlast;
  logic [TID_W-1:0]     m_tid;

  modport slave (
    input  s_tvalid, s_tdata, s_tstrb, s_tuser, s_tlast, m_tready,
    output s_tready, m_tvalid, m_tdata, m_tstrb, m_tuser, m_tlast, m_tid
  );

  modport master (
    output s_tvalid, s_tdata, s_tstrb, s_tuser, s_tlast, m_tready,
    input  s_tready, m_tvalid, m_tdata, m_tstrb, m_tuser, m_tlast, m_tid
  );
endinterface

// File: rtl/cddip_ib_arbiter_skid.sv
// ---------------------------------------------------------------------------
// cddip_axis_skid
// Two-entry registered skid buffer for any packed beat type T.
//   clk, rst      : clock, asynchronous active-high reset
//   in_valid_i    : upstream valid        in_ready_o : upstream ready
//   in_data_i     : upstream beat
//   out_valid_o   : downstream valid      out_ready_i: downstream ready
//   out_data_o    : downstream beat (head entry)
// in_ready_o depends only on the occupancy register, so there is no
// combinational path from out_ready_i back to in_ready_o.
// ---------------------------------------------------------------------------
module cddip_axis_skid
  import cddip_ib_arb_pkg::*;
#(
  parameter type T = ib_beat_t
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid_i,
  output logic in_ready_o,
  input  T     in_data_i,
  output logic out_valid_o,
  input  logic out_ready_i,
  output T     out_data_o
);

  logic [1:0] cnt_q, cnt_d;
  T           head_q, head_d;
  T           tail_q, tail_d;
  logic       push, pop;

  assign in_ready_o  = (cnt_q != 2'd2);
  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = head_q;
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    unique case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = in_data_i;
        else               tail_d = in_data_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        // Leaving one entry: promote the tail. Going empty: keep head as is.
        if (cnt_q == 2'd2) head_d = tail_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        // Push implies not full, so occupancy here is exactly one.
        head_d = in_data_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

endmodule

// File: rtl/cddip_ib_arbiter.sv
// ---------------------------------------------------------------------------
// cddip_ib_arbiter
// Frame-granular round-robin arbiter in front of the CDD engine inbound port.
// A grant is held from the first beat to tlast; one ARB cycle separates
// frames. Each output beat carries the granted source index on m_tid.
//   clk, rst    : engine clock, asynchronous active-high reset
//   ib          : s_* per-source streams in, m_* engine stream out
//   chan_en     : per-source enable for new grants
//   arb_idle    : no grant held and skid buffer empty
//   timeout_err : sticky per-source stall flag (CDDIP_IB_ARB_TIMEOUT_EN only)
// Build option: define CDDIP_IB_ARB_TIMEOUT_EN to add the mid-frame stall
// counter, the timeout_err port and the TIMEOUT_CYCLES parameter.
// ---------------------------------------------------------------------------
module cddip_ib_arbiter
  import cddip_ib_arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int TID_W  = `AXI_S_TID_WIDTH
`ifdef CDDIP_IB_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 10000
`endif
) (
  input  logic              clk,
  input  logic              rst,
  cddip_ib_arbiter_if.slave ib,
  input  logic [NUM_CH-1:0] chan_en,
  output logic              arb_idle
`ifdef CDDIP_IB_ARB_TIMEOUT_EN
  ,
  output logic [NUM_CH-1:0] timeout_err
`endif
);

  localparam int PTR_W = $clog2(NUM_CH);
  localparam logic [PTR_W-1:0] LAST_CH = PTR_W'(NUM_CH - 1);

  arb_state_e        state_q, state_d;
  logic [PTR_W-1:0]  gnt_q, gnt_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic [PTR_W:0]    pick;
  logic              skid_in_ready, skid_out_valid;
  logic              gnt_valid, beat_acc;
  ib_beat_t          in_beat, out_beat;

  // Returns {found, index}: first requester at or above ptr, wrapping.
  // Iterating the offset downward lets the nearest requester win.
  function automatic logic [PTR_W:0] rr_pick(input logic [NUM_CH-1:0] req,
                                             input logic [PTR_W-1:0]  ptr);
    logic [PTR_W:0]   res;
    logic [PTR_W-1:0] sel;
    res = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      sel = PTR_W'((int'(ptr) + k) % NUM_CH);
      if (req[sel]) res = {1'b1, sel};
    end
    return res;
  endfunction

  assign pick      = rr_pick(ib.s_tvalid & chan_en, rr_ptr_q);
  assign gnt_valid = ib.s_tvalid[gnt_q];
  assign beat_acc  = (state_q == PASS) && gnt_valid && skid_in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      ARB: begin
        if (pick[PTR_W]) begin
          gnt_d    = pick[PTR_W-1:0];
          rr_ptr_d = (pick[PTR_W-1:0] == LAST_CH) ? '0 : pick[PTR_W-1:0] + 1'b1;
          state_d  = PASS;
        end
      end
      PASS: begin
        if (beat_acc && ib.s_tlast[gnt_q]) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  always_comb begin
    ib.s_tready = '0;
    if (state_q == PASS) ib.s_tready[gnt_q] = skid_in_ready;
  end

  // Granted-lane mux feeding the skid buffer.
  always_comb begin
    in_beat = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (gnt_q == PTR_W'(c)) begin
        in_beat.data = ib.s_tdata[c*64 +: 64];
        in_beat.strb = ib.s_tstrb[c*8 +: 8];
        in_beat.user = ib.s_tuser[c*8 +: 8];
        in_beat.last = ib.s_tlast[c];
      end
    end
    in_beat.tid = TID_MAX_W'(gnt_q);
  end

  cddip_axis_skid #(.T(ib_beat_t)) u_skid (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (beat_acc),
    .in_ready_o  (skid_in_ready),
    .in_data_i   (in_beat),
    .out_valid_o (skid_out_valid),
    .out_ready_i (ib.m_tready),
    .out_data_o  (out_beat)
  );

  assign ib.m_tvalid = skid_out_valid;
  assign ib.m_tdata  = out_beat.data;
  assign ib.m_tstrb  = out_beat.strb;
  assign ib.m_tuser  = out_beat.user;
  assign ib.m_tlast  = out_beat.last;
  assign ib.m_tid    = out_beat.tid[TID_W-1:0];
  assign arb_idle    = (state_q == ARB) && !skid_out_valid;

`ifdef CDDIP_IB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [NUM_CH-1:0] err_q, err_d;

  // Counts cycles the granted source leaves a frame hanging; saturates.
  always_comb begin
    stall_d = stall_q;
    err_d   = err_q;
    if (state_q != PASS || beat_acc) begin
      stall_d = '0;
    end else if (!gnt_valid) begin
      if (stall_q != CNT_W'(TIMEOUT_CYCLES)) stall_d = stall_q + 1'b1;
      if (stall_d == CNT_W'(TIMEOUT_CYCLES)) err_d[gnt_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      err_q   <= '0;
    end else begin
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign timeout_err = err_q;
`endif

endmodule

// File: tb/tb_cddip_ib_arbiter.sv
module tb_cddip_ib_arbiter;
  import cddip_ib_arb_pkg::*;

  localparam int NCH  = 4;
  localparam int TIDW = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] chan_en;
  logic           arb_idle;
`ifdef CDDIP_IB_ARB_TIMEOUT_EN
  logic [NCH-1:0] timeout_err;
`endif

  int checks = 0;
  int errors = 0;

  cddip_ib_arbiter_if #(.NUM_CH(NCH), .TID_W(TIDW)) ifc ();

  cddip_ib_arbiter #(
    .NUM_CH(NCH),
    .TID_W (TIDW)
`ifdef CDDIP_IB_ARB_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ib      (ifc.slave),
    .chan_en (chan_en),
    .arb_idle(arb_idle)
`ifdef CDDIP_IB_ARB_TIMEOUT_EN
    ,
    .timeout_err(timeout_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic lane(input int c, input logic [63:0] d, input logic [7:0] u, input logic l);
    ifc.s_tdata[c*64 +: 64] = d;
    ifc.s_tstrb[c*8 +: 8]   = 8'hFF;
    ifc.s_tuser[c*8 +: 8]   = u;
    ifc.s_tlast[c]          = l;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [63:0] pat(input int c, input int b);
    return 64'hC0DE_0000_0000_0000 | (64'(c) << 8) | 64'(b);
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int             bc[NCH];
    logic [NCH-1:0] accp;
    int             ech;

    ifc.s_tvalid = '0;
    ifc.s_tdata  = '0;
    ifc.s_tstrb  = '0;
    ifc.s_tuser  = '0;
    ifc.s_tlast  = '0;
    ifc.m_tready = 1'b1;
    chan_en      = 4'hF;
    rst          = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_m_tvalid", ifc.m_tvalid, 0);
    chk("rst_m_tdata",  ifc.m_tdata, 0);
    chk("rst_m_tlast",  ifc.m_tlast, 0);
    chk("rst_m_tid",    ifc.m_tid, 0);
    chk("rst_s_tready", ifc.s_tready, 0);
    chk("rst_arb_idle", arb_idle, 1);
    rst = 1'b0;

    // Single source ch0, 4-beat frame
    ifc.s_tvalid = 4'b0001;
    lane(0, 64'h1111_0000_0000_0009, SOT, 1'b0);
    tick();
    chk("t1_ready", ifc.s_tready, 4'b0001);
    chk("t1_busy",  arb_idle, 0);
    tick();
    chk("t1_v0",    ifc.m_tvalid, 1);
    chk("t1_d0",    ifc.m_tdata, 64'h1111_0000_0000_0009);
    chk("t1_u0",    ifc.m_tuser, SOT);
    chk("t1_tid0",  ifc.m_tid, 0);
    lane(0, 64'h1111_0000_0000_0001, MID, 1'b0);
    tick();
    chk("t1_d1",    ifc.m_tdata, 64'h1111_0000_0000_0001);
    lane(0, 64'h1111_0000_0000_0002, MID, 1'b0);
    tick();
    chk("t1_d2",    ifc.m_tdata, 64'h1111_0000_0000_0002);
    lane(0, 64'h1111_0000_0000_0003, EOT, 1'b1);
    tick();
    chk("t1_d3",    ifc.m_tdata, 64'h1111_0000_0000_0003);
    chk("t1_last",  ifc.m_tlast, 1);
    chk("t1_u3",    ifc.m_tuser, EOT);
    chk("t1_rdy_arb", ifc.s_tready, 0);
    ifc.s_tvalid = '0;
    tick();
    chk("t1_idle",  arb_idle, 1);
    chk("t1_empty", ifc.m_tvalid, 0);

    // All four sources, back-to-back 2-beat frames
    do_reset();
    ifc.s_tvalid = 4'hF;
    for (int c = 0; c < NCH; c++) begin
      bc[c] = 0;
      lane(c, pat(c, 0), SOT, 1'b0);
    end
    accp = '0;
    for (int n = 0; n < 15; n++) begin
      tick();
      for (int c = 0; c < NCH; c++) begin
        if (accp[c]) bc[c] ^= 1;
        lane(c, pat(c, bc[c]), (bc[c] == 0) ? SOT : EOT, bc[c] == 1);
      end
      accp = ifc.s_tready;
      ech  = (n / 3) % NCH;
      chk("t2_onehot", ($countones(ifc.s_tready) <= 1), 1);
      if (n % 3 == 0) begin
        chk("t2_gap", ifc.m_tvalid, 0);
      end else begin
        chk("t2_valid", ifc.m_tvalid, 1);
        chk("t2_tid",   ifc.m_tid, ech);
        chk("t2_data",  ifc.m_tdata, pat(ech, (n % 3) - 1));
      end
    end
    ifc.s_tvalid = '0;
    tick();
    tick();
    chk("t2_idle", arb_idle, 1);

    // Backpressure on ch2 (rr_ptr is 1 here)
    ifc.s_tvalid = 4'b0100;
    lane(2, 64'hD000_0000_0000_0000, SOT, 1'b0);
    tick();
    chk("t3_ready", ifc.s_tready, 4'b0100);
    tick();
    chk("t3_d0", ifc.m_tdata, 64'hD000_0000_0000_0000);
    ifc.m_tready = 1'b0;
    lane(2, 64'hD000_0000_0000_0001, MID, 1'b0);
    tick();
    chk("t3_full", ifc.s_tready, 0);
    chk("t3_hold", ifc.m_tdata, 64'hD000_0000_0000_0000);
    lane(2, 64'hD000_0000_0000_0002, MID, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t3_stall_v",   ifc.m_tvalid, 1);
      chk("t3_stall_d",   ifc.m_tdata, 64'hD000_0000_0000_0000);
      chk("t3_stall_rdy", ifc.s_tready, 0);
    end
    ifc.m_tready = 1'b1;
    tick();
    chk("t3_d1",    ifc.m_tdata, 64'hD000_0000_0000_0001);
    chk("t3_reopen", ifc.s_tready, 4'b0100);
    tick();
    chk("t3_d2", ifc.m_tdata, 64'hD000_0000_0000_0002);
    lane(2, 64'hD000_0000_0000_0003, EOT, 1'b1);
    tick();
    chk("t3_d3",   ifc.m_tdata, 64'hD000_0000_0000_0003);
    chk("t3_last", ifc.m_tlast, 1);
    chk("t3_tid",  ifc.m_tid, 2);
    ifc.s_tvalid = '0;
    tick();
    chk("t3_empty", ifc.m_tvalid, 0);

    // chan_en[1] cleared during ch1's frame (rr_ptr is 3 here)
    ifc.s_tvalid = 4'b0010;
    lane(1, 64'hE000_0000_0000_0000, SOT, 1'b0);
    tick();
    chk("t4_ready", ifc.s_tready, 4'b0010);
    tick();
    chk("t4_d0", ifc.m_tdata, 64'hE000_0000_0000_0000);
    chan_en = 4'b1101;
    lane(1, 64'hE000_0000_0000_0001, MID, 1'b0);
    tick();
    chk("t4_keep", ifc.s_tready, 4'b0010);
    chk("t4_d1",   ifc.m_tdata, 64'hE000_0000_0000_0001);
    lane(1, 64'hE000_0000_0000_0002, EOT, 1'b1);
    tick();
    chk("t4_d2",   ifc.m_tdata, 64'hE000_0000_0000_0002);
    chk("t4_last", ifc.m_tlast, 1);
    lane(1, 64'hE000_0000_0000_0010, SOT, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t4_skip", ifc.s_tready, 0);
    end
    chk("t4_idle", arb_idle, 1);
    ifc.s_tvalid = '0;
    chan_en      = 4'hF;

    // Reset pulse mid-frame on ch2 (rr_ptr is 2 here)
    ifc.s_tvalid = 4'b0100;
    lane(2, 64'hF000_0000_0000_0000, SOT, 1'b0);
    tick();
    chk("t5_ready", ifc.s_tready, 4'b0100);
    tick();
    lane(2, 64'hF000_0000_0000_0001, MID, 1'b0);
    tick();
    chk("t5_mid", ifc.m_tdata, 64'hF000_0000_0000_0001);
    rst = 1'b1;
    #1;
    chk("t5_rst_v",    ifc.m_tvalid, 0);
    chk("t5_rst_d",    ifc.m_tdata, 0);
    chk("t5_rst_tid",  ifc.m_tid, 0);
    chk("t5_rst_last", ifc.m_tlast, 0);
    chk("t5_rst_rdy",  ifc.s_tready, 0);
    chk("t5_rst_idle", arb_idle, 1);
    @(negedge clk);
    rst = 1'b0;
    ifc.s_tvalid = 4'b1100;
    lane(2, 64'hF200_0000_0000_0000, SOT, 1'b0);
    lane(3, 64'hF300_0000_0000_0000, SOT, 1'b0);
    tick();
    chk("t5_first", ifc.s_tready, 4'b0100);
    tick();
    chk("t5_tid",  ifc.m_tid, 2);
    chk("t5_data", ifc.m_tdata, 64'hF200_0000_0000_0000);
    ifc.s_tvalid = '0;
    tick();

`ifdef CDDIP_IB_ARB_TIMEOUT_EN
    // Mid-frame stall on ch3 with a 16-cycle limit
    do_reset();
    chk("to_rst", timeout_err, 0);
    ifc.s_tvalid = 4'b1000;
    lane(3, 64'hA300_0000_0000_0000, SOT, 1'b0);
    tick();
    tick();
    chk("to_d0", ifc.m_tdata, 64'hA300_0000_0000_0000);
    ifc.s_tvalid = '0;
    lane(3, 64'hA300_0000_0000_0001, EOT, 1'b1);
    for (int k = 0; k < 15; k++) tick();
    chk("to_early", timeout_err, 0);
    tick();
    chk("to_set", timeout_err, 4'b1000);
    ifc.s_tvalid = 4'b1000;
    tick();
    chk("to_d1",   ifc.m_tdata, 64'hA300_0000_0000_0001);
    chk("to_last", ifc.m_tlast, 1);
    ifc.s_tvalid = '0;
    tick();
    tick();
    chk("to_sticky", timeout_err, 4'b1000);
    chk("to_idle",   arb_idle, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
